// File: rtl/ddr_arbiter_if.sv
// Bundle of requester-side and AXI-side signals for ddr_arbiter.
// master: the arbiter's view; slave: the environment (cameras, HDMI reader, DDR AXI port).
interface ddr_arbiter_if #(
    parameter int unsigned ADDR_W = 28
);
    // camera writers and HDMI reader
    logic [1:0]        wr_req;
    logic [ADDR_W-1:0] wr_addr0;
    logic [ADDR_W-1:0] wr_addr1;
    logic [255:0]      wr_data0;
    logic [255:0]      wr_data1;
    logic [1:0]        wr_ready;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [2:0]        grant;
    logic [2:0]        done;

    // AXI write address / data
    logic [ADDR_W-1:0] axi_awaddr;
    logic [3:0]        axi_awlen;
    logic              axi_awvalid;
    logic              axi_awready;
    logic [255:0]      axi_wdata;
    logic [31:0]       axi_wstrb;
    logic              axi_wready;
    logic              axi_wusero_last;

    // AXI read address / data
    logic [ADDR_W-1:0] axi_araddr;
    logic [3:0]        axi_arlen;
    logic              axi_arvalid;
    logic              axi_arready;
    logic              axi_rlast;
    logic              axi_rvalid;

    // constant sideband
    logic [3:0]        axi_awuser_id;
    logic [3:0]        axi_aruser_id;
    logic              axi_awuser_ap;
    logic              axi_aruser_ap;

    modport master (
        input  wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1, rd_req, rd_addr,
        input  axi_awready, axi_wready, axi_wusero_last,
        input  axi_arready, axi_rlast, axi_rvalid,
        output grant, done, wr_ready,
        output axi_awaddr, axi_awlen, axi_awvalid, axi_wdata, axi_wstrb,
        output axi_araddr, axi_arlen, axi_arvalid,
        output axi_awuser_id, axi_aruser_id, axi_awuser_ap, axi_aruser_ap
    );

    modport slave (
        output wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1, rd_req, rd_addr,
        output axi_awready, axi_wready, axi_wusero_last,
        output axi_arready, axi_rlast, axi_rvalid,
        input  grant, done, wr_ready,
        input  axi_awaddr, axi_awlen, axi_awvalid, axi_wdata, axi_wstrb,
        input  axi_araddr, axi_arlen, axi_arvalid,
        input  axi_awuser_id, axi_aruser_id, axi_awuser_ap, axi_aruser_ap
    );
endinterface

// File: rtl/ddr_arbiter.sv
// DDR AXI arbiter: two camera writers (round-robin) and one HDMI reader (priority).
// Optional macro ARB_STARVE_GUARD_EN: after RD_MAX consecutive read grants with a
// writer waiting, the next arbitration prefers the writers.
module ddr_arbiter #(
    parameter int unsigned ADDR_W    = 28,
    parameter logic [3:0]  BURST_LEN = 4'd15,
    parameter int unsigned RD_MAX    = 4
) (
    input  logic          clk,
    input  logic          rst,
    ddr_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        grant_q, grant_d;
    logic [2:0]        done_q, done_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              awvalid_q, awvalid_d;
    logic              arvalid_q, arvalid_d;
    logic              rr_q, rr_d;          // 1: wr1 wins the next writer tie
    logic [2:0]        winner_c;
    logic              starve_c;

    if (RD_MAX == 0) begin : g_rd_max_chk
        $error("ddr_arbiter: RD_MAX must be at least 1");
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(RD_MAX + 1);

    logic [CNT_W-1:0] starve_q, starve_d;

    assign starve_c = (starve_q >= CNT_W'(RD_MAX));

    // Count consecutive read grants made while a writer waits; any write grant clears it
    always_comb begin
        starve_d = starve_q;
        if (state_q == ST_IDLE && |winner_c) begin
            if (!winner_c[2]) begin
                starve_d = '0;
            end else if (!(|bus.wr_req)) begin
                starve_d = '0;
            end else if (!starve_c) begin
                starve_d = starve_q + CNT_W'(1);
            end
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign starve_c = 1'b0;
`endif

    // Winner selection: read first unless starving writers, then round-robin writers
    always_comb begin
        winner_c = 3'b000;
        if (bus.rd_req && !(starve_c && (|bus.wr_req))) begin
            winner_c = 3'b100;
        end else if (bus.wr_req == 2'b11) begin
            winner_c = rr_q ? 3'b010 : 3'b001;
        end else if (bus.wr_req[0]) begin
            winner_c = 3'b001;
        end else if (bus.wr_req[1]) begin
            winner_c = 3'b010;
        end
    end

    // Next-state and registered-output logic of the burst FSM
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        done_d    = 3'b000;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        awvalid_d = awvalid_q;
        arvalid_d = arvalid_q;
        rr_d      = rr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|winner_c) begin
                    grant_d = winner_c;
                    state_d = ST_ADDR;
                    if (winner_c[2]) begin
                        araddr_d  = bus.rd_addr;
                        arvalid_d = 1'b1;
                    end else begin
                        awaddr_d  = winner_c[1] ? bus.wr_addr1 : bus.wr_addr0;
                        awvalid_d = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (grant_q[2]) begin
                    if (bus.axi_arready) begin
                        arvalid_d = 1'b0;
                        state_d   = ST_DATA;
                    end
                end else if (bus.axi_awready) begin
                    awvalid_d = 1'b0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (grant_q[2] ? (bus.axi_rvalid && bus.axi_rlast)
                               : (bus.axi_wready && bus.axi_wusero_last)) begin
                    state_d = ST_DONE;
                    done_d  = grant_q;
                    grant_d = 3'b000;
                    if (!grant_q[2]) begin
                        rr_d = grant_q[0];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= 3'b000;
            done_q    <= 3'b000;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            awvalid_q <= 1'b0;
            arvalid_q <= 1'b0;
            rr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            awvalid_q <= awvalid_d;
            arvalid_q <= arvalid_d;
            rr_q      <= rr_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.done        = done_q;
    assign bus.axi_awaddr  = awaddr_q;
    assign bus.axi_awvalid = awvalid_q;
    assign bus.axi_awlen   = BURST_LEN;
    assign bus.axi_araddr  = araddr_q;
    assign bus.axi_arvalid = arvalid_q;
    assign bus.axi_arlen   = BURST_LEN;

    // Write data path steered by the current writer; wready only reaches that writer
    assign bus.axi_wdata = grant_q[1] ? bus.wr_data1 : bus.wr_data0;
    assign bus.axi_wstrb = '1;
    assign bus.wr_ready  = {bus.axi_wready & grant_q[1], bus.axi_wready & grant_q[0]};

    assign bus.axi_awuser_id = '0;
    assign bus.axi_aruser_id = '0;
    assign bus.axi_awuser_ap = 1'b0;
    assign bus.axi_aruser_ap = 1'b0;

endmodule

// File: tb/tb_ddr_arbiter.sv
// Directed bench for ddr_arbiter: bench plays the requesters and the DDR AXI slave.
module tb_ddr_arbiter;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    ddr_arbiter_if #(.ADDR_W(28)) bus ();

    ddr_arbiter #(.ADDR_W(28), .BURST_LEN(4'd15), .RD_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pat(input logic ch, input int b);
        return (ch ? 32'hB000_0000 : 32'hA000_0000) | 32'(b);
    endfunction

    task automatic clear_inputs();
        bus.wr_req          = 2'b00;
        bus.wr_addr0        = '0;
        bus.wr_addr1        = '0;
        bus.wr_data0        = '0;
        bus.wr_data1        = '0;
        bus.rd_req          = 1'b0;
        bus.rd_addr         = '0;
        bus.axi_awready     = 1'b0;
        bus.axi_wready      = 1'b0;
        bus.axi_wusero_last = 1'b0;
        bus.axi_arready     = 1'b0;
        bus.axi_rlast       = 1'b0;
        bus.axi_rvalid      = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One full burst starting in IDLE with requests already applied; ends in the DONE cycle.
    // drop_beat >= 0 releases all requests on that data beat.
    task automatic do_burst(input string tag, input logic [2:0] exp_gnt,
                            input logic [27:0] exp_addr, input int drop_beat);
        logic [31:0] p;
        tick();
        chk({tag, " grant"}, 64'(bus.grant), 64'(exp_gnt));
        if (exp_gnt[2]) begin
            chk({tag, " arvalid"}, 64'(bus.axi_arvalid), 64'd1);
            chk({tag, " araddr"}, 64'(bus.axi_araddr), 64'(exp_addr));
            chk({tag, " arlen"}, 64'(bus.axi_arlen), 64'd15);
        end else begin
            chk({tag, " awvalid"}, 64'(bus.axi_awvalid), 64'd1);
            chk({tag, " awaddr"}, 64'(bus.axi_awaddr), 64'(exp_addr));
            chk({tag, " awlen"}, 64'(bus.axi_awlen), 64'd15);
        end
        tick();
        chk({tag, " valid held"}, 64'(bus.axi_awvalid | bus.axi_arvalid), 64'd1);
        if (exp_gnt[2]) bus.axi_arready = 1'b1;
        else            bus.axi_awready = 1'b1;
        tick();
        bus.axi_arready = 1'b0;
        bus.axi_awready = 1'b0;
        chk({tag, " valid drop"}, 64'(bus.axi_awvalid | bus.axi_arvalid), 64'd0);
        for (int b = 0; b < 16; b++) begin
            if (b == drop_beat) begin
                bus.rd_req = 1'b0;
                bus.wr_req = 2'b00;
            end
            if (exp_gnt[2]) begin
                bus.axi_rvalid = 1'b1;
                bus.axi_rlast  = (b == 15);
            end else begin
                bus.axi_wready      = 1'b1;
                bus.axi_wusero_last = (b == 15);
                bus.wr_data0        = {8{pat(1'b0, b)}};
                bus.wr_data1        = {8{pat(1'b1, b)}};
            end
            #1;
            chk({tag, " grant in data"}, 64'(bus.grant), 64'(exp_gnt));
            if (exp_gnt[2]) begin
                chk({tag, " wr_ready on read"}, 64'(bus.wr_ready), 64'd0);
            end else begin
                p = pat(exp_gnt[1], b);
                chk({tag, " wdata"}, bus.axi_wdata[63:0], {p, p});
                chk({tag, " wr_ready"}, 64'(bus.wr_ready), 64'(exp_gnt[1:0]));
                if (b == 0) chk({tag, " wstrb"}, 64'(bus.axi_wstrb), 64'hFFFF_FFFF);
            end
            tick();
        end
        bus.axi_wready      = 1'b0;
        bus.axi_wusero_last = 1'b0;
        bus.axi_rvalid      = 1'b0;
        bus.axi_rlast       = 1'b0;
        chk({tag, " done pulse"}, 64'(bus.done), 64'(exp_gnt));
        chk({tag, " grant clear"}, 64'(bus.grant), 64'd0);
    endtask

    // Leave DONE for IDLE; done must already be gone
    task automatic to_idle(input string tag);
        tick();
        chk({tag, " done single"}, 64'(bus.done), 64'd0);
        chk({tag, " idle grant"}, 64'(bus.grant), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        clear_inputs();
        rst = 1'b1;
        bus.axi_wready = 1'b1;
        tick();
        tick();
        chk("rst grant", 64'(bus.grant), 64'd0);
        chk("rst done", 64'(bus.done), 64'd0);
        chk("rst wr_ready", 64'(bus.wr_ready), 64'd0);
        chk("rst awvalid", 64'(bus.axi_awvalid), 64'd0);
        chk("rst arvalid", 64'(bus.axi_arvalid), 64'd0);
        chk("rst awaddr", 64'(bus.axi_awaddr), 64'd0);
        chk("rst araddr", 64'(bus.axi_araddr), 64'd0);
        chk("rst user", 64'({bus.axi_awuser_id, bus.axi_aruser_id,
                             bus.axi_awuser_ap, bus.axi_aruser_ap}), 64'd0);
        bus.axi_wready = 1'b0;
        rst = 1'b0;

        // single write on wr0
        bus.wr_req   = 2'b01;
        bus.wr_addr0 = 28'h100;
        do_burst("single", 3'b001, 28'h100, -1);
        bus.wr_req = 2'b00;
        to_idle("single");
        tick();
        chk("no spurious grant", 64'(bus.grant), 64'd0);

        // reset on data beat 7 of a wr1 burst
        bus.wr_req   = 2'b10;
        bus.wr_addr1 = 28'h2A0;
        tick();
        chk("mrst grant", 64'(bus.grant), 64'b010);
        bus.axi_awready = 1'b1;
        tick();
        bus.axi_awready = 1'b0;
        for (int b = 0; b < 6; b++) begin
            bus.axi_wready = 1'b1;
            tick();
        end
        bus.axi_wready = 1'b1;
        rst = 1'b1;
        #1;
        chk("mrst grant async", 64'(bus.grant), 64'd0);
        chk("mrst wr_ready async", 64'(bus.wr_ready), 64'd0);
        chk("mrst awaddr async", 64'(bus.axi_awaddr), 64'd0);
        chk("mrst done async", 64'(bus.done), 64'd0);
        bus.axi_wready = 1'b0;
        bus.wr_req     = 2'b11;
        bus.wr_addr0   = 28'h300;
        bus.wr_addr1   = 28'h340;
        tick();
        rst = 1'b0;
        do_burst("post rst wr0", 3'b001, 28'h300, -1);
        bus.wr_req = 2'b00;
        to_idle("post rst wr0");

        // read priority, then round-robin writers between reads
        do_reset();
        bus.wr_req   = 2'b11;
        bus.wr_addr0 = 28'h400;
        bus.wr_addr1 = 28'h500;
        bus.rd_req   = 1'b1;
        bus.rd_addr  = 28'h600;
        do_burst("mix rd1", 3'b100, 28'h600, -1);
        bus.rd_req = 1'b0;
        to_idle("mix rd1");
        do_burst("mix wr0", 3'b001, 28'h400, -1);
        bus.rd_req  = 1'b1;
        bus.rd_addr = 28'h640;
        to_idle("mix wr0");
        do_burst("mix rd2", 3'b100, 28'h640, -1);
        bus.rd_req = 1'b0;
        to_idle("mix rd2");
        do_burst("mix wr1", 3'b010, 28'h500, -1);
        bus.wr_req = 2'b00;
        to_idle("mix wr1");

        // writer round-robin from reset
        do_reset();
        bus.wr_req   = 2'b11;
        bus.wr_addr0 = 28'h700;
        bus.wr_addr1 = 28'h780;
        do_burst("rr wr0a", 3'b001, 28'h700, -1);
        to_idle("rr wr0a");
        do_burst("rr wr1", 3'b010, 28'h780, -1);
        to_idle("rr wr1");
        do_burst("rr wr0b", 3'b001, 28'h700, -1);
        bus.wr_req = 2'b00;
        to_idle("rr wr0b");

        // read request dropped during data still completes
        bus.rd_req  = 1'b1;
        bus.rd_addr = 28'h8C0;
        do_burst("drop rd", 3'b100, 28'h8C0, 5);
        to_idle("drop rd");
        tick();
        chk("drop stays idle", 64'(bus.grant), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
